// File: rtl/axis_frame_encoder_pkg.sv
// Shared definitions for the byte-stream framer and its matching decoder.
package axis_frame_encoder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_COUNT,
        S_CSUM
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // SYNC, count and checksum bytes added around every payload.
    localparam int unsigned FRAME_OVERHEAD = 3;

endpackage

// File: rtl/axis_frame_encoder_if.sv
// Upstream (i*) and downstream (o*) byte-stream handshake bundle around the framer.
// The master modport is the framer itself; slave is the surrounding logic.
interface axis_frame_encoder_if;

    logic [7:0] idata;
    logic       ivalid;
    logic       iready;
    logic [7:0] odata;
    logic       ovalid;
    logic       oready;
    logic       olast;

    modport master (
        input  idata, ivalid, oready,
        output iready, odata, ovalid, olast
    );

    modport slave (
        output idata, ivalid, oready,
        input  iready, odata, ovalid, olast
    );

endinterface

// File: rtl/axis_idle_timer.sv
// Idle-cycle counter: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT-1 has been reached, holding there until cleared.
module axis_idle_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned   W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0]  LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] timer;

    assign expire = (timer == LIMIT);

    // Count idle cycles; saturate at the limit so the flag cannot wrap away.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (enable && !expire) begin
            timer <= timer + W'(1);
        end
    end

endmodule

// File: rtl/axis_frame_encoder.sv
// Byte-stream framer: SYNC, pass-through payload, count byte, checksum byte.
// A frame closes after PAYLOAD_LEN bytes or after TIMEOUT idle cycles.
module axis_frame_encoder
    import axis_frame_encoder_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN = 16,
    parameter int unsigned TIMEOUT     = 64,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    axis_frame_encoder_if.master bus,
    output logic                 busy
);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] sum;
    logic       xfer;
    logic       timer_clear;
    logic       timer_en;
    logic       timer_expire;

    axis_idle_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_idle_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (timer_expire)
    );

    assign busy = (state != S_IDLE);

    // Next-state and output decode; trailer bytes depend only on registers.
    always_comb begin
        state_next  = state;
        bus.iready  = 1'b0;
        bus.ovalid  = 1'b0;
        bus.odata   = '0;
        bus.olast   = 1'b0;
        xfer        = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.ivalid) state_next = S_SYNC;
            end
            S_SYNC: begin
                bus.ovalid = 1'b1;
                bus.odata  = SYNC_BYTE;
                if (bus.oready) state_next = S_DATA;
            end
            S_DATA: begin
                bus.odata  = bus.idata;
                bus.ovalid = bus.ivalid;
                bus.iready = bus.oready;
                xfer       = bus.ivalid && bus.oready;
                // A transfer both resets the timer and takes priority over expiry.
                if (xfer) begin
                    timer_clear = 1'b1;
                    if (cnt == 8'(PAYLOAD_LEN - 1)) state_next = S_COUNT;
                end else if (cnt != '0) begin
                    timer_en = 1'b1;
                    if (timer_expire) state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                bus.ovalid = 1'b1;
                bus.odata  = cnt;
                if (bus.oready) state_next = S_CSUM;
            end
            S_CSUM: begin
                bus.ovalid = 1'b1;
                bus.odata  = sum;
                bus.olast  = 1'b1;
                if (bus.oready) begin
                    state_next  = S_IDLE;
                    timer_clear = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register plus byte count and running checksum of the payload.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            sum   <= '0;
        end else begin
            state <= state_next;
            if (xfer) begin
                cnt <= cnt + 8'd1;
                sum <= sum + bus.idata;
            end else if (state == S_CSUM && bus.oready) begin
                cnt <= '0;
                sum <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_encoder.sv
// Scoreboard bench for axis_frame_encoder: one instance with the default
// 16-byte payload, one with a single-byte payload for back-to-back frames.
module tb_axis_frame_encoder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy0;
    logic busy1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] m_cnt;
    logic [7:0] m_sum;
    bit         rand_bp = 1'b0;

    axis_frame_encoder_if bus0();
    axis_frame_encoder_if bus1();

    axis_frame_encoder #(
        .PAYLOAD_LEN(16),
        .TIMEOUT    (64),
        .SYNC_BYTE  (8'hA5)
    ) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0),
        .busy  (busy0)
    );

    axis_frame_encoder #(
        .PAYLOAD_LEN(1),
        .TIMEOUT    (4),
        .SYNC_BYTE  (8'hA5)
    ) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1),
        .busy  (busy1)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Open a frame on dut0: expect SYNC first and restart the model.
    task automatic start0();
        q0.push_back(9'h0A5);
        m_cnt = '0;
        m_sum = '0;
    endtask

    // Expect the count/checksum trailer of the frame built so far.
    task automatic trailer0();
        q0.push_back({1'b0, m_cnt});
        q0.push_back({1'b1, m_sum});
    endtask

    // Offer one byte to dut0 and hold it until accepted.
    task automatic send0(input logic [7:0] b);
        int unsigned n = 0;
        bus0.idata  = b;
        bus0.ivalid = 1'b1;
        q0.push_back({1'b0, b});
        m_cnt = m_cnt + 8'd1;
        m_sum = m_sum + b;
        do begin
            @(negedge clock);
            n++;
        end while (!bus0.iready && n < 500);
        if (!bus0.iready) check("send0_timeout", bus0.iready, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic send1(input logic [7:0] b);
        int unsigned n = 0;
        bus1.idata  = b;
        bus1.ivalid = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!bus1.iready && n < 500);
        if (!bus1.iready) check("send1_timeout", bus1.iready, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int which);
        int unsigned n = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && n < 2000) begin
            @(posedge clock);
            n++;
        end
        #1;
        check((which == 0) ? "drain0" : "drain1", (which == 0) ? q0.size() : q1.size(), 0);
    endtask

    // Downstream ready for dut0: random when backpressure is enabled.
    initial begin
        bus0.oready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            bus0.oready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // dut0 output monitor: scoreboard pop plus hold-under-stall checks.
    initial begin : mon0
        logic [8:0] e;
        logic       stall;
        logic [7:0] held;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_valid0", bus0.ovalid, 1);
                    check("hold_data0", bus0.odata, held);
                end
                if (bus0.ovalid && bus0.oready) begin
                    if (q0.size() == 0) begin
                        check("unexpected0", {bus0.olast, bus0.odata}, 32'h200);
                    end else begin
                        e = q0.pop_front();
                        check("data0", bus0.odata, e[7:0]);
                        check("last0", bus0.olast, e[8]);
                    end
                end
                stall = bus0.ovalid && !bus0.oready;
                held  = bus0.odata;
            end
        end
    end

    // dut1 output monitor: scoreboard pop plus idle gap between frames.
    initial begin : mon1
        logic [8:0]  e;
        int unsigned n;
        int unsigned last_n;
        bit          have_last;
        n         = 0;
        last_n    = 0;
        have_last = 1'b0;
        forever begin
            @(negedge clock);
            n++;
            if (!reset && bus1.ovalid && bus1.oready) begin
                if (q1.size() == 0) begin
                    check("unexpected1", {bus1.olast, bus1.odata}, 32'h200);
                end else begin
                    e = q1.pop_front();
                    check("data1", bus1.odata, e[7:0]);
                    check("last1", bus1.olast, e[8]);
                    if (e == 9'h0A5 && have_last) check("idle_gap1", n - last_n, 2);
                    if (e[8]) begin
                        have_last = 1'b1;
                        last_n    = n;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int unsigned k;
        bus0.idata  = '0;
        bus0.ivalid = 1'b0;
        bus1.idata  = '0;
        bus1.ivalid = 1'b0;
        bus1.oready = 1'b1;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ovalid", bus0.ovalid, 0);
        check("rst_iready", bus0.iready, 0);
        check("rst_olast", bus0.olast, 0);
        check("rst_busy", busy0, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Full 16-byte frame, trailer pinned to known values
        q0.push_back(9'h0A5);
        for (int i = 0; i < 16; i++) begin
            bus0.idata  = 8'(i);
            bus0.ivalid = 1'b1;
            q0.push_back({1'b0, 8'(i)});
            k = 0;
            do begin
                @(negedge clock);
                k++;
            end while (!bus0.iready && k < 500);
            @(posedge clock);
            #1;
        end
        bus0.ivalid = 1'b0;
        q0.push_back(9'h010);
        q0.push_back(9'h178);
        drain(0);
        @(posedge clock);
        #1;
        check("busy_after_full", busy0, 0);

        // Short frame closed by the idle timeout
        start0();
        send0(8'h01);
        send0(8'h02);
        send0(8'h03);
        bus0.ivalid = 1'b0;
        trailer0();
        k = 0;
        do begin
            @(posedge clock);
            #1;
            k++;
        end while (!bus0.ovalid && k < 200);
        check("timeout_cycles", k, 64);
        drain(0);

        // Checksum wrap under random backpressure
        rand_bp = 1'b1;
        start0();
        for (int i = 0; i < 16; i++) send0(8'hFF);
        bus0.ivalid = 1'b0;
        trailer0();
        drain(0);
        rand_bp = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Reset in the middle of a frame discards it
        start0();
        for (int i = 0; i < 5; i++) send0(8'(8'h11 + i));
        bus0.ivalid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_ovalid", bus0.ovalid, 0);
        check("midrst_busy", busy0, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        start0();
        send0(8'h42);
        bus0.ivalid = 1'b0;
        trailer0();
        drain(0);

        // Single-byte frames back to back with ivalid held high
        q1.push_back(9'h0A5);
        q1.push_back(9'h010);
        q1.push_back(9'h001);
        q1.push_back(9'h110);
        send1(8'h10);
        q1.push_back(9'h0A5);
        q1.push_back(9'h020);
        q1.push_back(9'h001);
        q1.push_back(9'h120);
        send1(8'h20);
        bus1.ivalid = 1'b0;
        drain(1);
        @(posedge clock);
        #1;
        check("busy1_after", busy1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
